// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter (LSB first) with a TX FIFO and programmable baud divider.
// Stores to TXDATA queue bytes, STATUS exposes flow control, BAUDDIV sets the bit period (BAUDDIV+1 clocks).
module io_uart_tx #(
  parameter int WIDTH       = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 433
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       MemLen,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [WIDTH-1:0] out,
  output logic             tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   RST_DIV  = 16'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   bcnt_q, bcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic          rd_s, wr_s, is_word_s;
  logic [1:0]    sel_s;
  logic          full_s, empty_s, busy_s;
  logic          push_s, drop_s, pop_s, baud_wr_s, stat_rd_s, bit_end_s;
  logic [3:0]    cnt_sat_s;
  logic [WIDTH-1:0] status_s;
  logic          unused_s;

  assign unused_s = ^{in[WIDTH-1:16], addr[1:0]};

  assign rd_s      = CE & MemRead;
  assign wr_s      = CE & MemWrite;
  assign sel_s     = addr[3:2];
  assign is_word_s = (MemLen != 3'b000) && (MemLen != 3'b001);

  assign full_s    = (cnt_q == FULL_CNT);
  assign empty_s   = (cnt_q == {CW{1'b0}});
  assign busy_s    = (state_q != S_IDLE);
  assign bit_end_s = (bcnt_q == div_q);

  // A push while full is dropped even if the FSM frees a slot on the same edge.
  assign push_s    = wr_s && (sel_s == 2'd0) && !full_s;
  assign drop_s    = wr_s && (sel_s == 2'd0) && full_s;
  assign baud_wr_s = wr_s && (sel_s == 2'd2) && is_word_s;
  assign stat_rd_s = rd_s && (sel_s == 2'd1);

  // STATUS word assembly with saturated occupancy count
  always_comb begin
    if (32'(cnt_q) > 32'd15) begin
      cnt_sat_s = 4'd15;
    end else begin
      cnt_sat_s = 4'(cnt_q);
    end
    status_s = WIDTH'({cnt_sat_s, ovf_q, busy_s, empty_s, full_s});
  end

  // Load data mux
  always_comb begin
    out = {WIDTH{1'b0}};
    if (rd_s) begin
      case (sel_s)
        2'd1:    out = status_s;
        2'd2:    out = WIDTH'(baud_q);
        default: out = {WIDTH{1'b0}};
      endcase
    end else begin
      out = {WIDTH{1'b0}};
    end
  end

  // Serialiser next state; the divider is latched at pop so BAUDDIV writes only affect later frames
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    div_d   = div_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_q[rptr_q];
          div_d   = baud_q;
          bcnt_d  = 16'd0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          bcnt_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          bcnt_d  = bcnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          bcnt_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          bcnt_d  = bcnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          bcnt_d  = 16'd0;
          state_d = S_IDLE;
        end else begin
          bcnt_d  = bcnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line level follows the state being entered so tx changes on the same edge as the FSM
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy, overflow flag and divider register next state
  always_comb begin
    wptr_d = push_s ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d = pop_s  ? (rptr_q + AW'(1)) : rptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (stat_rd_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    baud_d = baud_wr_s ? in[15:0] : baud_q;
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      ovf_q   <= 1'b0;
      baud_q  <= RST_DIV;
      div_q   <= 16'd0;
      bcnt_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      bcnt_q  <= bcnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      if (push_s) begin
        fifo_q[wptr_q] <= in[7:0];
      end
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: directed scenarios plus randomized bus traffic,
// with the serial line compared every clock against a frame-timeline reference model.
module tb_io_uart_tx;

  logic        CLK  = 1'b0;
  logic        RST  = 1'b1;
  logic        CE   = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] din  = 32'h0;
  logic [2:0]  len  = 3'b000;
  logic        rd   = 1'b0;
  logic        wr   = 1'b0;
  logic [31:0] dout;
  logic        tx;

  int errors = 0;
  int checks = 0;

  io_uart_tx #(.WIDTH(32), .FIFO_DEPTH(8), .DEFAULT_DIV(433)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .addr(addr), .in(din), .MemLen(len),
    .MemRead(rd), .MemWrite(wr), .out(dout), .tx(tx)
  );

  always #5 CLK = ~CLK;

  // Reference model: byte queue plus the start edge, byte and bit period of the current frame
  logic [7:0] mq[$];
  int         baud_m   = 433;
  bit         ovf_m    = 1'b0;
  bit         in_frame = 1'b0;
  int         fs       = 0;
  int         fp       = 1;
  logic [7:0] fb       = 8'h00;
  int         cyc      = 0;

  function automatic bit m_busy();
    return in_frame && ((cyc - fs) < 10 * fp);
  endfunction

  function automatic logic m_tx();
    int idx;
    if (!m_busy()) return 1'b1;
    idx = (cyc - fs) / fp;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return fb[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    logic [3:0] c;
    n = mq.size();
    c = (n > 15) ? 4'd15 : 4'(n);
    return {24'h0, c, ovf_m, m_busy(), (n == 0), (n == 8)};
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] sel);
    case (sel)
      2'd1:    return m_status();
      2'd2:    return 32'(baud_m);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    bit idle_pre;
    int sz;
    logic [1:0] sel;
    idle_pre = !m_busy();
    sz = mq.size();
    sel = addr[3:2];
    cyc++;
    if (RST) begin
      mq.delete();
      ovf_m = 1'b0;
      baud_m = 433;
      in_frame = 1'b0;
    end else begin
      if (idle_pre && sz > 0) begin
        fb = mq.pop_front();
        fs = cyc;
        fp = baud_m + 1;
        in_frame = 1'b1;
      end
      if (CE && wr && sel == 2'd0) begin
        if (sz == 8) ovf_m = 1'b1;
        else mq.push_back(din[7:0]);
      end else if (CE && rd && sel == 2'd1) begin
        ovf_m = 1'b0;
      end
      if (CE && wr && sel == 2'd2 && len != 3'b000 && len != 3'b001) baud_m = int'(din[15:0]);
    end
  endtask

  // Line monitor: advance the model on each edge and compare tx just after it
  always @(posedge CLK) begin
    model_edge();
    #1;
    checks++;
    if (tx !== m_tx()) begin
      errors++;
      $display("FAIL tx_line cyc=%0d got=%b exp=%b", cyc, tx, m_tx());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus(input bit c, input bit r, input bit w, input logic [3:0] a,
                     input logic [31:0] d, input logic [2:0] l, output logic [31:0] q);
    CE = c; rd = r; wr = w; addr = a; din = d; len = l;
    #2;
    q = dout;
    @(posedge CLK);
    #1;
    CE = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; din = 32'h0; len = 3'b000;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d, input logic [2:0] l);
    logic [31:0] q;
    bus(1'b1, 1'b0, 1'b1, a, d, l, q);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] q);
    bus(1'b1, 1'b1, 1'b0, a, 32'h0, 3'b010, q);
  endtask

  task automatic test_reset();
    logic [31:0] q;
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    rd_reg(4'h4, q);
    checks++;
    if (q !== 32'h02) begin errors++; $display("FAIL reset_status got=%h exp=02", q); end
    rd_reg(4'h8, q);
    checks++;
    if (q !== 32'd433) begin errors++; $display("FAIL reset_bauddiv got=%0d exp=433", q); end
  endtask

  task automatic test_frame();
    logic [31:0] q;
    logic [7:0] pat;
    logic exp;
    int idx;
    pat = 8'hA5;
    wr_reg(4'h8, 32'd3, 3'b010);
    wr_reg(4'h0, 32'hA5, 3'b000);
    for (int j = 0; j < 40; j++) begin
      idle(1);
      idx = j / 4;
      exp = (idx == 0) ? 1'b0 : ((idx <= 8) ? pat[idx-1] : 1'b1);
      if (j == 0 || (j % 4) == 2) begin
        checks++;
        if (tx !== exp) begin errors++; $display("FAIL frame_bit j=%0d got=%b exp=%b", j, tx, exp); end
      end
    end
    rd_reg(4'h4, q);
    checks++;
    if (q !== 32'h06) begin errors++; $display("FAIL frame_busy_end got=%h exp=06", q); end
    rd_reg(4'h4, q);
    checks++;
    if (q !== 32'h02) begin errors++; $display("FAIL frame_idle got=%h exp=02", q); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] q;
    logic [7:0] sent[$];
    logic [7:0] got, exp_b;
    int waited;
    wr_reg(4'h8, 32'd1, 3'b010);
    for (int i = 0; i < 9; i++) begin
      got = 8'($urandom);
      sent.push_back(got);
      wr_reg(4'h0, {24'h0, got}, 3'b000);
    end
    rd_reg(4'h4, q);
    checks++;
    if (q !== 32'h85) begin errors++; $display("FAIL fifo_full_status got=%h exp=85", q); end
    wr_reg(4'h0, 32'hFF, 3'b000);
    void'(sent.pop_front());
    idle(11);
    for (int f = 0; f < 8; f++) begin
      waited = 0;
      while (tx !== 1'b0 && waited < 100) begin idle(1); waited++; end
      checks++;
      if (waited >= 100) begin errors++; $display("FAIL fifo_start_timeout frame=%0d", f); break; end
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin idle(2); got[i] = tx; end
      idle(2);
      exp_b = sent.pop_front();
      checks++;
      if (got !== exp_b || tx !== 1'b1) begin
        errors++;
        $display("FAIL fifo_order frame=%0d got=%h stop=%b exp=%h stop=1", f, got, tx, exp_b);
      end
    end
  endtask

  task automatic test_ovf();
    logic [31:0] q;
    idle(4);
    rd_reg(4'h4, q);
    checks++;
    if (q !== 32'h0A) begin errors++; $display("FAIL ovf_sticky got=%h exp=0a", q); end
    rd_reg(4'h4, q);
    checks++;
    if (q !== 32'h02) begin errors++; $display("FAIL ovf_clear got=%h exp=02", q); end
    wr_reg(4'h8, 32'h7, 3'b000);
    wr_reg(4'h8, 32'h7, 3'b001);
    rd_reg(4'h8, q);
    checks++;
    if (q !== 32'd1) begin errors++; $display("FAIL baud_narrow_write got=%0d exp=1", q); end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] q;
    wr_reg(4'h8, 32'd3, 3'b010);
    for (int i = 0; i < 3; i++) wr_reg(4'h0, 32'($urandom_range(0, 255)), 3'b000);
    idle(16);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx got=%b exp=1", tx); end
    rd_reg(4'h4, q);
    checks++;
    if (q !== 32'h02) begin errors++; $display("FAIL midreset_status got=%h exp=02", q); end
    wr_reg(4'h8, 32'd3, 3'b010);
    wr_reg(4'h0, 32'h3C, 3'b000);
    idle(1);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midreset_newstart got=%b exp=0", tx); end
    idle(45);
    rd_reg(4'h4, q);
    checks++;
    if (q !== 32'h02) begin errors++; $display("FAIL midreset_drained got=%h exp=02", q); end
  endtask

  task automatic test_baud_change();
    logic [31:0] q;
    logic exp;
    wr_reg(4'h8, 32'd3, 3'b010);
    wr_reg(4'h0, 32'($urandom_range(0, 255)) | 32'h1, 3'b000);
    wr_reg(4'h0, 32'($urandom_range(0, 255)) | 32'h1, 3'b000);
    wr_reg(4'h8, 32'd7, 3'b010);
    for (int j = 3; j <= 50; j++) begin
      idle(1);
      if (j == 4 || j == 5 || j == 41 || j == 42 || j == 49 || j == 50) begin
        exp = (j == 4 || j == 42 || j == 49) ? 1'b0 : 1'b1;
        checks++;
        if (tx !== exp) begin errors++; $display("FAIL baud_change j=%0d got=%b exp=%b", j, tx, exp); end
      end
    end
    idle(80);
    bus(1'b0, 1'b1, 1'b0, 4'h4, 32'h0, 3'b010, q);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL ce0_read got=%h exp=0", q); end
    bus(1'b0, 1'b0, 1'b1, 4'h0, 32'h55, 3'b000, q);
    bus(1'b0, 1'b1, 1'b1, 4'h8, 32'h2, 3'b010, q);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL ce0_rdwr got=%h exp=0", q); end
    rd_reg(4'h4, q);
    checks++;
    if (q !== 32'h02) begin errors++; $display("FAIL ce0_no_push got=%h exp=02", q); end
    rd_reg(4'h8, q);
    checks++;
    if (q !== 32'd7) begin errors++; $display("FAIL ce0_no_baud got=%0d exp=7", q); end
  endtask

  task automatic test_random();
    logic [31:0] q, exp, d;
    logic [3:0] a;
    bit c, r, w;
    int waited;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 3) != 0);
      r = 1'($urandom);
      w = 1'($urandom);
      a = 4'($urandom);
      d = (a[3:2] == 2'd2) ? 32'($urandom_range(0, 3)) : $urandom;
      exp = (c && r) ? m_read(a[3:2]) : 32'h0;
      bus(c, r, w, a, d, 3'($urandom), q);
      checks++;
      if (q !== exp) begin errors++; $display("FAIL rand_read i=%0d addr=%h got=%h exp=%h", i, a, q, exp); end
    end
    waited = 0;
    while ((m_busy() || mq.size() != 0) && waited < 2000) begin idle(1); waited++; end
    checks++;
    if (waited >= 2000) begin errors++; $display("FAIL rand_drain_timeout"); end
    exp = m_status();
    rd_reg(4'h4, q);
    checks++;
    if (q !== exp) begin errors++; $display("FAIL rand_final_status got=%h exp=%h", q, exp); end
  endtask

  initial begin
    @(posedge CLK);
    #1;
    test_reset();
    test_frame();
    test_fifo_full();
    test_ovf();
    test_midframe_reset();
    test_baud_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
